bus_term_ctrl: RTL and testbench
================================

// Module: bus_term_ctrl
// PURPOSE
//  68000 bus-cycle termination controller; sits directly upstream of the bus watchdog.
//  Tracks each CPU bus cycle from AS_n, counts device wait states and drives DTACK_n.
//  Holds the watchdog clear (wd_clr) while no cycle is pending.
//  Forwards a watchdog timeout to the CPU as BERR_n, held until the cycle ends.
// PARAMETERS
//  WAIT_W    4   width of dev_wait and of the internal wait-state counter
// PORTS
//  clk          in   1       system clock, the single clock domain
//  clr          in   1       reset, synchronous, active-high
//  as_n         in   1       CPU address strobe, asynchronous; 2-flop synchronised internally
//  dev_sel      in   1       address decoder hit, sampled when cycle start is detected
//  dev_ext      in   1       1: selected device supplies its own dev_dtack_n
//  dev_wait     in   WAIT_W  wait states for internally acknowledged devices
//  dev_dtack_n  in   1       external device acknowledge, active-low
//  wd_berr_n    in   1       watchdog timeout, active-low
//  wd_clr       out  1       watchdog clear, active-high
//  dtack_n      out  1       DTACK to CPU, active-low, registered
//  berr_n       out  1       BERR to CPU, active-low, registered
//  busy         out  1       1 while state != IDLE
//  berr_cnt     out  8       bus-error count (only with BUS_TERM_BERR_CNT_EN)
// BEHAVIOUR
//  - Reset (clr=1 at edge): state=IDLE, sync flops=1, dtack_n=1, berr_n=1, wd_clr=1, busy=0, cnt=0.
//  - as_s = as_n after 2 flops; all decisions use as_s only.
//  - States: IDLE, WAIT, EXT, NOMAP, ACK, ERR. wd_clr=1 in IDLE/ACK/ERR, 0 otherwise.
//  - IDLE, as_s=0 at cycle N; dev_sel/dev_ext/dev_wait sampled at N:
//      dev_sel=0                 -> NOMAP
//      dev_sel=1, dev_ext=1      -> EXT
//      dev_sel=1, dev_wait=0     -> ACK (dtack_n=0 in cycle N+1)
//      dev_sel=1, dev_wait=k>0   -> WAIT, cnt=k
//  - WAIT: cnt==1 -> ACK; otherwise cnt<=cnt-1. dtack_n goes low in cycle N+1+k.
//  - EXT: dev_dtack_n=0 -> ACK (1 cycle latency). NOMAP: waits for timeout only.
//  - WAIT/EXT/NOMAP: wd_berr_n=0 -> ERR; berr_n=0 from next cycle.
//  - Same cycle in WAIT (cnt==1) or EXT (dev_dtack_n=0) with wd_berr_n=0: ACK wins, no BERR.
//  - WAIT/EXT/NOMAP with as_s=1 (aborted cycle): -> IDLE. No DTACK/BERR; this check outranks all others.
//  - ACK: dtack_n=0 until as_s=1, then -> IDLE; dtack_n=1 from that next cycle.
//  - ERR: berr_n=0 until as_s=1, then -> IDLE; berr_n=1 from that next cycle.
//  - IDLE always lasts >=1 cycle between cycles; a new as_s=0 is seen only in IDLE.
//  - dtack_n and berr_n are never both 0.
//  - clr mid-cycle: next cycle is IDLE with outputs at reset values, regardless of as_s.
// CONFIGURATION
//  - BUS_TERM_BERR_CNT_EN defined: berr_cnt is an 8-bit saturating counter.
//    +1 on each entry to ERR; holds at 255; cleared by clr.
//  - Not defined: berr_cnt port and counter are absent; all else identical.
// TESTING
//  1. dev_sel=1, dev_ext=0, dev_wait=0, as_n low -> dtack_n=0 exactly 1 cycle after as_s falls;
//     released 1 cycle after as_s rises.
//  2. dev_wait=5 -> dtack_n low at N+6; wd_clr=0 from N+1 to N+5, 1 at N+6; berr_n stays 1.
//  3. dev_sel=0, wd_berr_n driven low 128 cycles in -> berr_n=0 next cycle, wd_clr=1,
//     held until as_n rises; berr_cnt=1 if enabled.
//  4. EXT: dev_dtack_n=0 and wd_berr_n=0 in same cycle -> dtack_n=0, berr_n=1.
//  5. as_n rises in WAIT with cnt=3 -> IDLE next cycle, dtack_n never low;
//     clr during ACK -> dtack_n=1 next cycle.
//  6. 300 timeouts with BUS_TERM_BERR_CNT_EN -> berr_cnt=255; clr -> 0.

Source files
------------

// File: rtl/bus_term_ctrl_if.sv
// rtl/bus_term_ctrl_if.sv - CPU bus, device decode and watchdog signals of the termination controller
interface bus_term_ctrl_if #(parameter int WAIT_W = 4) ();
   logic              as_n;
   logic              dev_sel;
   logic              dev_ext;
   logic [WAIT_W-1:0] dev_wait;
   logic              dev_dtack_n;
   logic              wd_berr_n;
   logic              wd_clr;
   logic              dtack_n;
   logic              berr_n;
   logic              busy;

   modport master (
      output as_n, dev_sel, dev_ext, dev_wait, dev_dtack_n, wd_berr_n,
      input  wd_clr, dtack_n, berr_n, busy
   );

   modport slave (
      input  as_n, dev_sel, dev_ext, dev_wait, dev_dtack_n, wd_berr_n,
      output wd_clr, dtack_n, berr_n, busy
   );
endinterface

// File: rtl/bus_term_ctrl.sv
// rtl/bus_term_ctrl.sv - 68000 bus-cycle termination (DTACK/BERR) ahead of the bus watchdog
// Optional saturating bus-error counter on berr_cnt when BUS_TERM_BERR_CNT_EN is defined.
module bus_term_ctrl #(
   parameter int WAIT_W = 4
) (
   input  logic       clk,
   input  logic       clr,
`ifdef BUS_TERM_BERR_CNT_EN
   output logic [7:0] berr_cnt,
`endif
   bus_term_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_WAIT, ST_EXT, ST_NOMAP, ST_ACK, ST_ERR
   } state_t;

   state_t            state, nxt;
   logic              as_s1, as_s;
   logic [WAIT_W-1:0] cnt, cnt_nxt;
   logic              dtack_q, berr_q, wd_clr_q, busy_q;

   // Strobe release (abort or normal end) is tested first in every non-idle state.
   always_comb begin
      nxt     = state;
      cnt_nxt = cnt;
      case (state)
         ST_IDLE: begin
            if (!as_s) begin
               if (!bus.dev_sel)
                  nxt = ST_NOMAP;
               else if (bus.dev_ext)
                  nxt = ST_EXT;
               else if (bus.dev_wait == '0)
                  nxt = ST_ACK;
               else begin
                  nxt     = ST_WAIT;
                  cnt_nxt = bus.dev_wait;
               end
            end
         end
         ST_WAIT: begin
            if (as_s)
               nxt = ST_IDLE;
            else if (cnt == WAIT_W'(1))
               nxt = ST_ACK;
            else if (!bus.wd_berr_n)
               nxt = ST_ERR;
            else
               cnt_nxt = cnt - WAIT_W'(1);
         end
         ST_EXT: begin
            if (as_s)
               nxt = ST_IDLE;
            else if (!bus.dev_dtack_n)
               nxt = ST_ACK;
            else if (!bus.wd_berr_n)
               nxt = ST_ERR;
         end
         ST_NOMAP: begin
            if (as_s)
               nxt = ST_IDLE;
            else if (!bus.wd_berr_n)
               nxt = ST_ERR;
         end
         ST_ACK, ST_ERR: begin
            if (as_s)
               nxt = ST_IDLE;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   // Outputs are derived from the next state so they change together with it.
   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= ST_IDLE;
         as_s1    <= 1'b1;
         as_s     <= 1'b1;
         cnt      <= '0;
         dtack_q  <= 1'b1;
         berr_q   <= 1'b1;
         wd_clr_q <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         as_s1    <= bus.as_n;
         as_s     <= as_s1;
         state    <= nxt;
         cnt      <= cnt_nxt;
         dtack_q  <= (nxt != ST_ACK);
         berr_q   <= (nxt != ST_ERR);
         wd_clr_q <= (nxt == ST_IDLE) || (nxt == ST_ACK) || (nxt == ST_ERR);
         busy_q   <= (nxt != ST_IDLE);
      end
   end

`ifdef BUS_TERM_BERR_CNT_EN
   always_ff @(posedge clk) begin
      if (clr)
         berr_cnt <= 8'd0;
      else if (nxt == ST_ERR && state != ST_ERR && berr_cnt != 8'hFF)
         berr_cnt <= berr_cnt + 8'd1;
   end
`endif

   assign bus.dtack_n = dtack_q;
   assign bus.berr_n  = berr_q;
   assign bus.wd_clr  = wd_clr_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_bus_term_ctrl.sv
// tb/tb_bus_term_ctrl.sv - scoreboard bench for bus_term_ctrl (berr_cnt checks with BUS_TERM_BERR_CNT_EN)
`timescale 1ns/1ps
module tb_bus_term_ctrl;
   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   bus_term_ctrl_if #(.WAIT_W(4)) bus ();
`ifdef BUS_TERM_BERR_CNT_EN
   logic [7:0] berr_cnt;
`endif

   bus_term_ctrl #(.WAIT_W(4)) dut (
      .clk      (clk),
      .clr      (clr),
`ifdef BUS_TERM_BERR_CNT_EN
      .berr_cnt (berr_cnt),
`endif
      .bus      (bus)
   );

   int    errors  = 0;
   int    checks  = 0;
   int    exp_cnt = 0;
   string tag_q[$];
   int    val_q[$];

   task automatic check_eq(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   function automatic void sb_push(input string tag, input int val);
      tag_q.push_back(tag);
      val_q.push_back(val);
   endfunction

   task automatic sb_pop(input string tag, input int act);
      string et;
      int    ev;
      if (tag_q.size() == 0) begin
         check_eq({tag, "_unexpected"}, act, -999);
      end else begin
         et = tag_q.pop_front();
         ev = val_q.pop_front();
         check_eq(et, act, ev);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // n counts edges after as_n is driven low; the device sees the strobe at n=2, terminates from n=3.
   task automatic do_cycle(input logic sel, input logic ext, input int wt, input int ack_at,
                           input int to_at, input int abort_at, input int exp_dt, input int exp_be);
      int rel_at, first_dt, first_be, rel_lat, both;
      rel_at   = (abort_at >= 0) ? abort_at : (((exp_dt > exp_be) ? exp_dt : exp_be) + 4);
      first_dt = -1;
      first_be = -1;
      rel_lat  = -1;
      both     = 0;
      sb_push("wd_clr_n3",    (exp_dt == 3) ? 1 : 0);
      sb_push("hold_dtack_n", (exp_dt >= 0) ? 0 : 1);
      sb_push("hold_berr_n",  (exp_be >= 0) ? 0 : 1);
      sb_push("hold_wd_clr",  (exp_dt >= 0 || exp_be >= 0) ? 1 : 0);
      sb_push("hold_busy",    1);
      sb_push("dtack_lat",    exp_dt);
      sb_push("berr_lat",     exp_be);
      sb_push("release_lat",  3);
      sb_push("both_low",     0);
      if (exp_be >= 0 && exp_cnt < 255) exp_cnt++;
      bus.dev_sel  = sel;
      bus.dev_ext  = ext;
      bus.dev_wait = 4'(wt);
      bus.as_n     = 1'b0;
      for (int n = 1; n <= rel_at + 8; n++) begin
         tick();
         if (!bus.dtack_n && first_dt < 0) first_dt = n;
         if (!bus.berr_n && first_be < 0) first_be = n;
         if (!bus.dtack_n && !bus.berr_n) both++;
         if (n == 3) sb_pop("wd_clr_n3", int'(bus.wd_clr));
         if (n == rel_at) begin
            sb_pop("hold_dtack_n", int'(bus.dtack_n));
            sb_pop("hold_berr_n",  int'(bus.berr_n));
            sb_pop("hold_wd_clr",  int'(bus.wd_clr));
            sb_pop("hold_busy",    int'(bus.busy));
         end
         if (n > rel_at && rel_lat < 0 && !bus.busy && bus.dtack_n && bus.berr_n)
            rel_lat = n - rel_at;
         if (n == ack_at) bus.dev_dtack_n = 1'b0;
         if (n == to_at)  bus.wd_berr_n   = 1'b0;
         if (n == rel_at) begin
            bus.as_n        = 1'b1;
            bus.dev_sel     = 1'b0;
            bus.dev_dtack_n = 1'b1;
            bus.wd_berr_n   = 1'b1;
         end
      end
      sb_pop("dtack_lat",   first_dt);
      sb_pop("berr_lat",    first_be);
      sb_pop("release_lat", rel_lat);
      sb_pop("both_low",    both);
`ifdef BUS_TERM_BERR_CNT_EN
      check_eq("berr_cnt", int'(berr_cnt), exp_cnt);
`endif
   endtask

   initial begin
      bus.as_n        = 1'b1;
      bus.dev_sel     = 1'b0;
      bus.dev_ext     = 1'b0;
      bus.dev_wait    = 4'd0;
      bus.dev_dtack_n = 1'b1;
      bus.wd_berr_n   = 1'b1;
      clr             = 1'b1;
      repeat (3) tick();
      check_eq("rst_dtack_n", int'(bus.dtack_n), 1);
      check_eq("rst_berr_n",  int'(bus.berr_n),  1);
      check_eq("rst_wd_clr",  int'(bus.wd_clr),  1);
      check_eq("rst_busy",    int'(bus.busy),    0);
`ifdef BUS_TERM_BERR_CNT_EN
      check_eq("rst_berr_cnt", int'(berr_cnt), 0);
`endif
      clr = 1'b0;
      tick();

      //        sel   ext  wait ack  to   abort dtack berr
      do_cycle(1'b1, 1'b0, 0,  -1,  -1,  -1,   3,   -1);
      do_cycle(1'b1, 1'b0, 5,  -1,  -1,  -1,   8,   -1);
      do_cycle(1'b1, 1'b0, 1,  -1,  -1,  -1,   4,   -1);
      do_cycle(1'b1, 1'b0, 15, -1,  -1,  -1,   18,  -1);
      do_cycle(1'b0, 1'b0, 0,  -1,  128, -1,  -1,   129);
      do_cycle(1'b0, 1'b1, 3,  -1,  10,  -1,  -1,   11);
      do_cycle(1'b1, 1'b1, 0,  5,   5,   -1,   6,   -1);
      do_cycle(1'b1, 1'b1, 2,  10,  -1,  -1,   11,  -1);
      do_cycle(1'b1, 1'b1, 0,  -1,  20,  -1,  -1,   21);
      do_cycle(1'b1, 1'b0, 9,  -1,  6,   -1,  -1,   7);
      do_cycle(1'b1, 1'b0, 5,  -1,  7,   -1,   8,   -1);
      do_cycle(1'b1, 1'b0, 8,  -1,  -1,  6,   -1,   -1);
      do_cycle(1'b0, 1'b0, 0,  -1,  -1,  10,  -1,   -1);

      bus.dev_sel  = 1'b1;
      bus.dev_ext  = 1'b0;
      bus.dev_wait = 4'd0;
      bus.as_n     = 1'b0;
      repeat (3) tick();
      check_eq("clr_pre_dtack_n", int'(bus.dtack_n), 0);
      clr = 1'b1;
      tick();
      check_eq("clr_dtack_n", int'(bus.dtack_n), 1);
      check_eq("clr_busy",    int'(bus.busy),    0);
      check_eq("clr_wd_clr",  int'(bus.wd_clr),  1);
      bus.as_n    = 1'b1;
      bus.dev_sel = 1'b0;
      clr         = 1'b0;
      exp_cnt     = 0;
      repeat (4) tick();
      check_eq("post_clr_busy", int'(bus.busy), 0);

`ifdef BUS_TERM_BERR_CNT_EN
      for (int i = 0; i < 300; i++)
         do_cycle(1'b0, 1'b0, 0, -1, 3, -1, -1, 4);
      check_eq("sat_berr_cnt", int'(berr_cnt), 255);
      clr = 1'b1;
      tick();
      check_eq("clr_berr_cnt", int'(berr_cnt), 0);
      clr = 1'b0;
      tick();
`endif

      check_eq("sb_leftover", tag_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1);
   end
endmodule
